if_stage: RTL and testbench

Instruction-fetch stage of the RV32 core, directly upstream of the decode stage. Holds the fetch PC, issues in-order word requests to instruction memory with up to two outstanding, buffers returned instructions in a 2-entry queue, and presents `{pc, instruction}` to decode over the valid/ready pipeline handshake. A branch or jump redirect from execute flushes the queue and discards in-flight responses before fetching from the target.

---
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: RV32 instruction-fetch stage.
//   Keeps the fetch PC and issues in-order word requests to instruction
//   memory (at most two outstanding). Returned words go into a 2-entry
//   {pc, instr} queue, which is presented to decode over a valid/ready
//   handshake. A redirect from execute flushes the queue, discards any
//   responses still in flight and restarts fetch at the target.
// Ports:
//   clk, rst_b                 clock, asynchronous active-low reset
//   imem_req/addr/gnt          request channel to instruction memory
//   imem_rvalid/rdata          in-order response channel
//   id_pipe_valid/ready        handshake to decode
//   id_pc, id_instruction      queue head presented to decode
//   ex_redirect, ex_redirect_pc  taken branch / jump from execute
module if_stage #(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_pipe_ready,
  output logic            id_pipe_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instruction,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_redirect_pc
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [1:0]      outstanding;
  logic [1:0]      drop_cnt;
  logic [1:0]      fifo_count;
  logic            rd_ptr;
  logic            wr_ptr;
  logic [XLEN-1:0] pc_q    [2];
  logic [XLEN-1:0] instr_q [2];

  logic            pop;
  logic            grant;
  logic            discard;
  logic            push;
  logic [2:0]      credit_used;
  logic [XLEN-1:0] target;

  assign target        = ex_redirect_pc & ~XLEN'(3);
  assign id_pipe_valid = (fifo_count != 2'd0) & ~ex_redirect;
  assign pop           = id_pipe_valid & id_pipe_ready;

  // Credit counts queue slots already promised: entries held plus words in
  // flight, less the one leaving this cycle. Request only if a slot remains.
  assign credit_used   = 3'(outstanding) + 3'(fifo_count) - 3'(pop);
  assign imem_req      = rst_b & ~ex_redirect & (credit_used < 3'd2);
  assign imem_addr     = fetch_pc;
  assign grant         = imem_req & imem_gnt;

  // A response is thrown away if it belongs to a pre-redirect request.
  assign discard       = (drop_cnt != 2'd0) | ex_redirect;
  assign push          = imem_rvalid & ~discard;

  assign id_pc          = pc_q[rd_ptr];
  assign id_instruction = instr_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      pc_q[0]     <= RESET_PC;
      pc_q[1]     <= RESET_PC;
      instr_q[0]  <= NOP;
      instr_q[1]  <= NOP;
    end else begin
      outstanding <= outstanding + 2'(grant) - 2'(imem_rvalid);
      if (ex_redirect) begin
        // Everything still in flight (minus what returns now) must be dropped.
        fetch_pc   <= target;
        resp_pc    <= target;
        drop_cnt   <= outstanding - 2'(imem_rvalid);
        fifo_count <= '0;
        rd_ptr     <= 1'b0;
        wr_ptr     <= 1'b0;
      end else begin
        if (grant)
          fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rvalid && drop_cnt != 2'd0)
          drop_cnt <= drop_cnt - 2'd1;
        if (push) begin
          pc_q[wr_ptr]    <= resp_pc;
          instr_q[wr_ptr] <= imem_rdata;
          wr_ptr          <= ~wr_ptr;
          resp_pc         <= resp_pc + XLEN'(4);
        end
        if (pop)
          rd_ptr <= ~rd_ptr;
        fifo_count <= fifo_count + 2'(push) - 2'(pop);
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage. A small instruction memory with
// selectable 1- or 2-cycle latency answers each granted address A with ~A.
module tb_if_stage;

  logic        clk;
  logic        rst_b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_pipe_ready;
  logic        id_pipe_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;

  int n_checks;
  int n_fail;
  int lat;

  if_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_pipe_ready  (id_pipe_ready),
    .id_pipe_valid  (id_pipe_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .ex_redirect    (ex_redirect),
    .ex_redirect_pc (ex_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: in-order, fixed latency, reset by the same rst_b.
  logic        s_v;
  logic [31:0] s_a;
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s_v         <= 1'b0;
      s_a         <= '0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      s_v <= imem_req & imem_gnt;
      s_a <= imem_addr;
      if (lat == 1) begin
        imem_rvalid <= imem_req & imem_gnt;
        imem_rdata  <= ~imem_addr;
      end else begin
        imem_rvalid <= s_v;
        imem_rdata  <= ~s_a;
      end
    end
  end

  // The credit rule must make a push into a full queue impossible.
  always @(negedge clk) begin
    if (rst_b) begin
      assert (!(dut.push && dut.fifo_count == 2'd2)) else begin
        n_checks++;
        n_fail++;
        $error("FAIL fifo_overflow: push with count=%0d, required count<2", dut.fifo_count);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Reset across two edges, release mid-cycle: returns in cycle 0.
  task automatic start(input int l, input logic rdy);
    rst_b         = 1'b0;
    lat           = l;
    id_pipe_ready = rdy;
    imem_gnt      = 1'b1;
    ex_redirect   = 1'b0;
    nxt();
    nxt();
    rst_b = 1'b1;
    #1;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_b          = 1'b0;
    lat            = 1;
    imem_gnt       = 1'b1;
    id_pipe_ready  = 1'b1;
    ex_redirect    = 1'b0;
    ex_redirect_pc = '0;

    // Reset values and streaming fetch at one instruction per cycle
    nxt();
    nxt();
    check("rst_req",   32'(imem_req),      32'd0);
    check("rst_valid", 32'(id_pipe_valid), 32'd0);
    check("rst_pc",    id_pc,              32'h0000_0000);
    check("rst_instr", id_instruction,     32'h0000_0013);
    rst_b = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("s1_req",  32'(imem_req), 32'd1);
      check("s1_addr", imem_addr,     32'(4 * k));
      if (k >= 2) begin
        check("s1_valid", 32'(id_pipe_valid), 32'd1);
        check("s1_pc",    id_pc,              32'(4 * (k - 2)));
        check("s1_instr", id_instruction,     ~32'(4 * (k - 2)));
      end else begin
        check("s1_valid0", 32'(id_pipe_valid), 32'd0);
      end
      nxt();
    end

    // Backpressure: two grants then stall, drain in order
    start(1, 1'b0);
    nxt();
    check("s2_req1",  32'(imem_req), 32'd1);
    check("s2_addr1", imem_addr,     32'h4);
    nxt();
    check("s2_req2",   32'(imem_req),      32'd0);
    check("s2_valid2", 32'(id_pipe_valid), 32'd1);
    check("s2_pc2",    id_pc,              32'h0);
    nxt();
    check("s2_req3",   32'(imem_req), 32'd0);
    check("s2_instr3", id_instruction, 32'hFFFF_FFFF);
    nxt();
    check("s2_req4", 32'(imem_req), 32'd0);
    id_pipe_ready = 1'b1;
    #1;
    check("s2_req4r",  32'(imem_req), 32'd1);
    check("s2_addr4r", imem_addr,     32'h8);
    check("s2_pc4r",   id_pc,         32'h0);
    nxt();
    check("s2_valid5", 32'(id_pipe_valid), 32'd1);
    check("s2_pc5",    id_pc,              32'h4);
    check("s2_instr5", id_instruction,     32'hFFFF_FFFB);
    nxt();
    check("s2_pc6",    id_pc,          32'h8);
    check("s2_instr6", id_instruction, 32'hFFFF_FFF7);

    // Grant stall at 0xC: address held for three ungranted cycles
    start(1, 1'b1);
    nxt();
    nxt();
    nxt();
    imem_gnt = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("s3_req_stall",  32'(imem_req), 32'd1);
      check("s3_addr_stall", imem_addr,     32'hC);
      if (k < 2) nxt();
    end
    check("s3_valid_empty", 32'(id_pipe_valid), 32'd0);
    nxt();
    imem_gnt = 1'b1;
    #1;
    check("s3_req_gnt",  32'(imem_req), 32'd1);
    check("s3_addr_gnt", imem_addr,     32'hC);
    nxt();
    check("s3_addr_next", imem_addr, 32'h10);
    nxt();
    check("s3_valid", 32'(id_pipe_valid), 32'd1);
    check("s3_pc",    id_pc,              32'hC);
    check("s3_instr", id_instruction,     32'hFFFF_FFF3);

    // Redirect with two outstanding, 2-cycle memory, unaligned target
    start(2, 1'b1);
    nxt();
    check("s4_addr1", imem_addr, 32'h4);
    nxt();
    check("s4_req_full", 32'(imem_req), 32'd0);
    ex_redirect    = 1'b1;
    ex_redirect_pc = 32'h0000_0103;
    #1;
    check("s4_valid_redir", 32'(id_pipe_valid), 32'd0);
    check("s4_req_redir",   32'(imem_req),      32'd0);
    nxt();
    ex_redirect = 1'b0;
    #1;
    check("s4_req_tgt",  32'(imem_req), 32'd1);
    check("s4_addr_tgt", imem_addr,     32'h100);
    check("s4_valid3",   32'(id_pipe_valid), 32'd0);
    nxt();
    check("s4_valid4", 32'(id_pipe_valid), 32'd0);
    check("s4_addr4",  imem_addr,          32'h104);
    nxt();
    check("s4_valid5", 32'(id_pipe_valid), 32'd0);
    check("s4_req5",   32'(imem_req),      32'd0);
    nxt();
    check("s4_valid6", 32'(id_pipe_valid), 32'd1);
    check("s4_pc6",    id_pc,              32'h100);
    check("s4_instr6", id_instruction,     32'hFFFF_FEFF);
    nxt();
    check("s4_pc7", id_pc, 32'h104);

    // Redirect coinciding with a response and a pop; then a wrapping target
    start(1, 1'b1);
    nxt();
    nxt();
    nxt();
    check("s5_pc_pre", id_pc, 32'h4);
    ex_redirect    = 1'b1;
    ex_redirect_pc = 32'h0000_0200;
    #1;
    check("s5_valid_redir", 32'(id_pipe_valid), 32'd0);
    check("s5_req_redir",   32'(imem_req),      32'd0);
    nxt();
    ex_redirect = 1'b0;
    #1;
    check("s5_valid4", 32'(id_pipe_valid), 32'd0);
    check("s5_addr4",  imem_addr,          32'h200);
    nxt();
    check("s5_valid5", 32'(id_pipe_valid), 32'd0);
    check("s5_addr5",  imem_addr,          32'h204);
    nxt();
    check("s5_valid6", 32'(id_pipe_valid), 32'd1);
    check("s5_pc6",    id_pc,              32'h200);
    check("s5_instr6", id_instruction,     32'hFFFF_FDFF);
    nxt();
    check("s5_pc7", id_pc, 32'h204);
    ex_redirect    = 1'b1;
    ex_redirect_pc = 32'hFFFF_FFFE;
    #1;
    nxt();
    ex_redirect = 1'b0;
    #1;
    check("s5_addr_top", imem_addr, 32'hFFFF_FFFC);
    nxt();
    check("s5_addr_wrap", imem_addr, 32'h0);
    nxt();
    check("s5_pc_top",    id_pc,          32'hFFFF_FFFC);
    check("s5_instr_top", id_instruction, 32'h0000_0003);

    // Asynchronous reset in mid-run with the queue full
    start(1, 1'b0);
    nxt();
    nxt();
    nxt();
    check("s6_valid_full", 32'(id_pipe_valid), 32'd1);
    id_pipe_ready = 1'b1;
    #1;
    check("s6_req_pre", 32'(imem_req), 32'd1);
    #1;
    rst_b = 1'b0;
    #1;
    check("s6_req_rst",   32'(imem_req),      32'd0);
    check("s6_valid_rst", 32'(id_pipe_valid), 32'd0);
    check("s6_pc_rst",    id_pc,              32'h0);
    check("s6_instr_rst", id_instruction,     32'h0000_0013);
    nxt();
    rst_b = 1'b1;
    #1;
    check("s6_req0",  32'(imem_req), 32'd1);
    check("s6_addr0", imem_addr,     32'h0);
    nxt();
    nxt();
    check("s6_valid2", 32'(id_pipe_valid), 32'd1);
    check("s6_pc2",    id_pc,              32'h0);
    check("s6_instr2", id_instruction,     32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
